// File: rtl/vga_ctrl_param.sv
// Parameterised VGA timing generator with a clock-enable pixel divider and a
// registered colour/sync output stage one pixel behind the address outputs.
module vga_ctrl_param #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int COLOR_W  = 4,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [3*COLOR_W-1:0] disp_RGB,
    output logic                 pix_ce,
    output logic [10:0]          h_addr,
    output logic [10:0]          v_addr,
    output logic [COLOR_W-1:0]   disp_r,
    output logic [COLOR_W-1:0]   disp_g,
    output logic [COLOR_W-1:0]   disp_b,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic                 frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
            $fatal(1, "vga_ctrl_param: H_TOTAL and V_TOTAL must not exceed 2048");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $fatal(1, "vga_ctrl_param: CLK_DIV must be in 1..16");
        end
    endgenerate

    // Comparisons run at 12 bits so that a 2048-wide region boundary still fits.
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_S = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_E = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_S = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_E = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic        HS_ACT   = 1'(HS_POL);
    localparam logic        VS_ACT   = 1'(VS_POL);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic [11:0] h_x;
    logic [11:0] v_x;
    logic        h_end;
    logic        v_end;
    logic        vis;

    // Pixel-rate clock enable; the counters and output stage all run off it.
    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign pix_ce = 1'b1;
        end else begin : g_div
            localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
            logic [3:0] div;

            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of process order.
            always_ff @(posedge clock or posedge rst) begin
                if (rst)
                    div <= '0;
                else if (div == DIV_LAST)
                    div <= '0;
                else
                    div <= div + 4'd1;
            end

            assign pix_ce = (div == DIV_LAST);
        end
    endgenerate

    assign h_x   = {1'b0, h_cnt};
    assign v_x   = {1'b0, v_cnt};
    assign h_end = (h_x == H_LAST);
    assign v_end = (v_x == V_LAST);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_end) begin
                h_cnt <= '0;
                v_cnt <= v_end ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    assign vis    = (h_x < H_ACT) && (v_x < V_ACT);
    assign h_addr = vis ? h_cnt : 11'd0;
    assign v_addr = vis ? v_cnt : 11'd0;

    // Output stage captures the pixel whose address was shown during the period
    // that this pix_ce closes; async reset forces blanking and idle syncs at once.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            disp_r <= '0;
            disp_g <= '0;
            disp_b <= '0;
            de     <= 1'b0;
            hsync  <= ~HS_ACT;
            vsync  <= ~VS_ACT;
        end else if (pix_ce) begin
            disp_b <= vis ? disp_RGB[3*COLOR_W-1:2*COLOR_W] : '0;
            disp_g <= vis ? disp_RGB[2*COLOR_W-1:COLOR_W]   : '0;
            disp_r <= vis ? disp_RGB[COLOR_W-1:0]           : '0;
            de     <= vis;
            hsync  <= (h_x >= H_SYNC_S && h_x <= H_SYNC_E) ? HS_ACT : ~HS_ACT;
            vsync  <= (v_x >= V_SYNC_S && v_x <= V_SYNC_E) ? VS_ACT : ~VS_ACT;
        end
    end

    // One-clock pulse alongside the registration of pixel (0,0).
    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            frame_start <= 1'b0;
        else
            frame_start <= pix_ce && (h_cnt == 11'd0) && (v_cnt == 11'd0);
    end

endmodule

// File: tb/tb_vga_ctrl_param.sv
// Directed bench for vga_ctrl_param: a divided instance (CLK_DIV=4, active-low
// syncs) and an undivided one (CLK_DIV=1, active-high syncs) on a tiny raster.
module tb_vga_ctrl_param;

    // Small raster: 16 pixels/line (8 visible, sync at 10..12), 8 lines/frame
    // (4 visible, sync on lines 5..6), 128 pixels per frame.
    localparam int HT = 16;
    localparam int FR = 128;

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic [11:0] rgb_a = 12'hF0A;
    logic [11:0] rgb_b = 12'hF0A;

    logic        pix_ce_a, hsync_a, vsync_a, de_a, fs_a;
    logic [10:0] h_addr_a, v_addr_a;
    logic [3:0]  r_a, g_a, b_a;
    logic        pix_ce_b, hsync_b, vsync_b, de_b, fs_b;
    logic [10:0] h_addr_b, v_addr_b;
    logic [3:0]  r_b, g_b, b_b;

    int checks = 0;
    int errors = 0;
    int n      = 0;
    bit addr_mode = 1'b0;

    always #5 clock = ~clock;

    vga_ctrl_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(4), .COLOR_W(4), .HS_POL(0), .VS_POL(0)
    ) dut_a (
        .clock(clock), .rst(rst), .disp_RGB(rgb_a), .pix_ce(pix_ce_a),
        .h_addr(h_addr_a), .v_addr(v_addr_a),
        .disp_r(r_a), .disp_g(g_a), .disp_b(b_a),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .frame_start(fs_a)
    );

    vga_ctrl_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .COLOR_W(4), .HS_POL(1), .VS_POL(1)
    ) dut_b (
        .clock(clock), .rst(rst), .disp_RGB(rgb_b), .pix_ce(pix_ce_b),
        .h_addr(h_addr_b), .v_addr(v_addr_b),
        .disp_r(r_b), .disp_g(g_b), .disp_b(b_b),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .frame_start(fs_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    // Expected colour for a registered pixel at (h,v) given the source mode.
    task automatic check_rgb(input string who, input bit vis, input int h, input int v,
                             input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        logic [3:0] er, eg, eb;
        er = 4'h0; eg = 4'h0; eb = 4'h0;
        if (vis) begin
            if (addr_mode) begin
                eb = 4'(h);
                eg = 4'(v);
            end else begin
                eb = 4'hF;
                er = 4'hA;
            end
        end
        check({who, "_r"}, r, er);
        check({who, "_g"}, g, eg);
        check({who, "_b"}, b, eb);
    endtask

    // n = rising edges since reset release; pixel ticks land on edges 4,8,...
    task automatic check_a();
        int k, cur, hc, vc, q, hq, vq;
        bit vis_c, vis_q;
        k     = n / 4;
        cur   = k % FR;
        hc    = cur % HT;
        vc    = cur / HT;
        vis_c = (hc < 8) && (vc < 4);
        check("a_pix_ce", pix_ce_a, (n % 4) == 3);
        check("a_h_addr", h_addr_a, vis_c ? hc : 0);
        check("a_v_addr", v_addr_a, vis_c ? vc : 0);
        check("a_frame_start", fs_a, (n >= 4) && ((n % (4 * FR)) == 4));
        if (k == 0) begin
            check("a_de_idle", de_a, 0);
            check("a_hsync_idle", hsync_a, 1);
            check("a_vsync_idle", vsync_a, 1);
            check_rgb("a_idle", 1'b0, 0, 0, r_a, g_a, b_a);
        end else begin
            q     = (k - 1) % FR;
            hq    = q % HT;
            vq    = q / HT;
            vis_q = (hq < 8) && (vq < 4);
            check("a_de", de_a, vis_q);
            check("a_hsync", hsync_a, !(hq >= 10 && hq <= 12));
            check("a_vsync", vsync_a, !(vq >= 5 && vq <= 6));
            check_rgb("a_pix", vis_q, hq, vq, r_a, g_a, b_a);
        end
    endtask

    // Undivided instance: every edge is a pixel tick, syncs active-high.
    task automatic check_b();
        int cur, hc, vc, q, hq, vq;
        bit vis_c, vis_q;
        cur   = n % FR;
        hc    = cur % HT;
        vc    = cur / HT;
        vis_c = (hc < 8) && (vc < 4);
        check("b_pix_ce", pix_ce_b, 1);
        check("b_h_addr", h_addr_b, vis_c ? hc : 0);
        check("b_v_addr", v_addr_b, vis_c ? vc : 0);
        check("b_frame_start", fs_b, (n % FR) == 1);
        if (n == 0) begin
            check("b_de_idle", de_b, 0);
            check("b_hsync_idle", hsync_b, 0);
            check("b_vsync_idle", vsync_b, 0);
            check_rgb("b_idle", 1'b0, 0, 0, r_b, g_b, b_b);
        end else begin
            q     = (n - 1) % FR;
            hq    = q % HT;
            vq    = q / HT;
            vis_q = (hq < 8) && (vq < 4);
            check("b_de", de_b, vis_q);
            check("b_hsync", hsync_b, hq >= 10 && hq <= 12);
            check("b_vsync", vsync_b, vq >= 5 && vq <= 6);
            check_rgb("b_pix", vis_q, hq, vq, r_b, g_b, b_b);
        end
    endtask

    task automatic drive();
        rgb_a = addr_mode ? {h_addr_a[3:0], v_addr_a[3:0], 4'h0} : 12'hF0A;
        rgb_b = addr_mode ? {h_addr_b[3:0], v_addr_b[3:0], 4'h0} : 12'hF0A;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            check_a();
            check_b();
            drive();
        end
    endtask

    initial begin
        // Reset held across several edges: everything idles, B's pix_ce stays high.
        #12;
        check_a();
        check_b();
        repeat (3) @(negedge clock);
        check_a();
        check_b();

        // Release on a falling edge; edge 4 registers pixel (0,0) on A, edge 1 on B.
        rst = 1'b0;
        n   = 0;
        drive();
        run(4 * FR);

        // Address-derived source: each output pixel must echo its own address.
        addr_mode = 1'b1;
        drive();
        run(4 * FR + 153);

        // A is mid-line on visible pixel (5,2); reset must blank it without a clock edge.
        check("a_de_before_rst", de_a, 1);
        rst = 1'b1;
        n   = 0;
        #1;
        check_a();
        check_b();
        repeat (3) @(negedge clock);
        check_a();
        check_b();

        // Restart from (0,0) with a single frame_start per instance frame.
        rst = 1'b0;
        drive();
        run(4 * FR + 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_ctrl_param.md
VGA_CTRL_PARAM -- requirements
Module: vga_ctrl_param

Interface
REQ-001 Parameters (name, default, meaning):
- H_ACTIVE 640: visible pixels/line. H_FP 16, H_SYNC 96, H_BP 48: front porch, sync, back porch, in pixels.
- V_ACTIVE 480: visible lines. V_FP 10, V_SYNC 2, V_BP 33: front porch, sync, back porch, in lines.
- CLK_DIV 4: clock cycles per pixel, range 1..16.
- COLOR_W 4: bits per colour channel.
- HS_POL 0, VS_POL 0: sync active level (0 = active-low).
REQ-002 Ports (name, direction, width, meaning):
- clock  in  1: system clock.
- rst  in  1: asynchronous active-high reset.
- disp_RGB  in  3*COLOR_W: pixel data packed {B,G,R}, B in the MSBs.
- pix_ce  out  1: pixel-tick strobe.
- h_addr  out  11: column of the current visible pixel.
- v_addr  out  11: row of the current visible pixel.
- disp_r, disp_g, disp_b  out  COLOR_W each: colour outputs.
- hsync, vsync  out  1: sync outputs.
- de  out  1: data enable.
- frame_start  out  1: start-of-frame pulse.

Function
REQ-003 Define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both SHALL be at most 2048; elaboration SHALL fail otherwise.
REQ-004 Divider div counts 0..CLK_DIV-1 on every clock and wraps to 0. pix_ce = 1 when div == CLK_DIV-1. When CLK_DIV = 1, pix_ce is constantly 1.
REQ-005 h_cnt and v_cnt (11 bits each) SHALL advance only on cycles where pix_ce = 1.
REQ-006 h_cnt counts 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt wraps to 0 when v_cnt == V_TOTAL-1 and h_cnt wraps in the same cycle.
REQ-007 Line layout: visible at h_cnt 0..H_ACTIVE-1, then front porch, sync, back porch. Frame layout: visible at v_cnt 0..V_ACTIVE-1, then front porch, sync, back porch.
REQ-008 vis = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-009 h_addr/v_addr SHALL be combinational: h_cnt/v_cnt when vis = 1, otherwise 0. They are stable for the whole pixel period.
REQ-010 disp_RGB SHALL be sampled on the pix_ce cycle that ends the pixel period; the source has CLK_DIV-1 clocks of lookup time.
REQ-011 Output register stage, updated only on pix_ce cycles, giving a fixed latency of 1 pixel from address to output:
- disp_b/g/r <= disp_RGB fields when vis = 1, else 0.
- de <= vis.
- hsync <= HS_POL when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~HS_POL.
- vsync <= VS_POL when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], else ~VS_POL.
REQ-012 frame_start SHALL be high for exactly one clock: the clock after the pix_ce edge that registers pixel (0,0), coincident with de rising for line 0.
REQ-013 There are no mid-frame parameter changes. Outputs hold their values between pix_ce cycles.

Reset
REQ-014 While rst = 1, asynchronously: div, h_cnt, v_cnt = 0; disp_r/g/b = 0; de = 0; frame_start = 0; hsync = ~HS_POL; vsync = ~VS_POL.
REQ-015 pix_ce is low during reset, except when CLK_DIV = 1.
REQ-016 After rst falls, the first pix_ce occurs on the CLK_DIV-th rising clock edge. The first registered pixel is (0,0), so frame_start pulses at the start of the first frame.
REQ-017 Reset asserted mid-line or mid-frame SHALL abort the frame immediately. There are no partial sync pulses after release.

Verification
REQ-018 Defaults, rst released, 3200 clocks -> pix_ce period 4 clocks; hsync low for 384 clocks starting 657*4 clocks after line start; hsync period 3200 clocks.
REQ-019 Defaults -> vsync low for exactly 2 lines (6400 clocks); frame period 525*3200 = 1,680,000 clocks; exactly one frame_start per frame.
REQ-020 disp_RGB held at 12'hF0A -> while de = 1: disp_b = F, disp_g = 0, disp_r = A; all channels 0 whenever de = 0; de high for 640 pixels/line on 480 lines.
REQ-021 Address/data alignment: source returns disp_RGB = {h_addr[3:0], v_addr[3:0], 4'h0} -> each output pixel matches the address of the preceding pixel period; h_addr/v_addr = 0 in blanking.
REQ-022 rst pulsed at h_cnt = 300, v_cnt = 200 -> outputs take reset values in the same cycle, without waiting for a clock edge; after release, counting restarts at (0,0) and frame_start pulses once.
REQ-023 CLK_DIV = 1, HS_POL = 1, VS_POL = 1 -> pix_ce constantly high; hsync high for 96 clocks per 800; vsync high for 1600 clocks per 420,000.
